cpu_trace_monitor: RTL
======================

// Module: cpu_trace_monitor
// PURPOSE
// - Synthesizable run monitor that sits beside cpu and observes its retire stream.
// - Stops the run on an address breakpoint or a cycle timeout, with NUM_BP breakpoint channels.
// - Keeps cycle and retire counters.
// - Holds the last TRACE_DEPTH retired PCs in a circular buffer; after halt a bench or debug host drains it through a valid/ready port.
// PARAMETERS
// XLEN         32    width of the PC and breakpoint addresses
// NUM_BP       2     number of breakpoint channels (1..8)
// TRACE_DEPTH  16    trace buffer entries; power of 2, 2..256
// CNT_W        32    width of the cycle and retire counters
// TIMEOUT      4096  cycle count that forces a halt; 0 disables the timeout
// PORTS
// clk            in   1              single clock, rising edge
// rst            in   1              synchronous, active-high reset
// retire_valid   in   1              one instruction retires this cycle
// retire_pc      in   XLEN           PC of the retiring instruction
// bp_en          in   NUM_BP         per-channel breakpoint enable
// bp_addr        in   NUM_BP*XLEN    channel i occupies [i*XLEN +: XLEN]
// halted         out  1              run has stopped
// halt_cause     out  2              0 none, 1 breakpoint, 2 timeout
// halt_bp_idx    out  $clog2(NUM_BP) channel that fired (max(1,..) bits)
// cycle_count    out  CNT_W          cycles spent in RUN
// retire_count   out  CNT_W          retires accepted in RUN
// trace_valid    out  1              trace_data holds an entry ready to pop
// trace_data     out  XLEN           oldest remaining traced PC
// trace_ready    in   1              consumer accepts trace_data
// trace_level    out  $clog2(TRACE_DEPTH)+1  entries currently held
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): state=RUN, all counters 0, buffer empty.
//   - All outputs are 0 one cycle after reset, with halt_cause=0.
//   - rst has priority over every event, including in the middle of a drain.
// - FSM RUN -> HALTED; HALTED persists until rst.
// - RUN:
//   - cycle_count increments every cycle.
//   - On retire_valid, retire_count increments and retire_pc is written at the write pointer.
//   - When the buffer is full, the oldest entry is overwritten: rd_ptr advances and trace_level stays at TRACE_DEPTH.
//   - trace_valid is held at 0 in RUN.
// - Breakpoint: retire_valid && bp_en[i] && retire_pc==bp_addr[i].
//   - The lowest matching i wins.
//   - The triggering PC is still written to the buffer as the newest entry and is counted in retire_count.
//   - halted, halt_cause=1 and halt_bp_idx are registered and visible the next cycle (latency 1).
// - Timeout: when TIMEOUT!=0 and cycle_count==TIMEOUT-1 in RUN, the FSM goes to HALTED next cycle with cause 2.
//   - cycle_count ends at TIMEOUT.
//   - A breakpoint in the same cycle wins and gives cause 1.
// - Counters saturate at all-ones; they never wrap.
// - HALTED:
//   - Counters are frozen; retire_valid and the bp inputs are ignored.
//   - trace_valid = (trace_level!=0).
//   - A pop on trace_valid && trace_ready advances rd_ptr and decrements trace_level.
//   - trace_data is stable while valid && !ready.
//   - Entries are drained oldest first; trace_ready with an empty buffer has no effect.
// - Pointers wrap modulo TRACE_DEPTH. Full is trace_level==TRACE_DEPTH.
// STRUCTURE
// - Shared package cpu_dbg_pkg:
//   - halt_cause_t enum {HC_NONE, HC_BP, HC_TIMEOUT}
//   - mon_state_t {MON_RUN, MON_HALTED}
// - Sub-module trace_ring:
//   - Parametric circular buffer (XLEN x TRACE_DEPTH), with push, pop, overwrite_when_full, level.
//   - Reusable for a later data-memory access trace.
// - The top level holds the FSM, the breakpoint comparator array (priority encoder) and the counters.
// TESTING (NUM_BP=2, TRACE_DEPTH=4, TIMEOUT=64)
// - Breakpoint stop:
//   - Stimulus: bp_addr0=0x108, bp_en=01, retire PCs 0x100,0x104,0x108.
//   - Required: halted, cause=1, idx=0, retire_count=3, drain yields 0x100,0x104,0x108.
// - Overwrite: 6 retires 0x0..0x14 with a breakpoint on 0x14.
//   - Required: level=4, drain yields 0x8,0xC,0x10,0x14.
// - Priority: bp0=bp1=0x20, both enabled, retire 0x20 -> idx=0.
//   - With bp_en=10 -> idx=1.
// - Timeout: no breakpoint hit, retire every cycle.
//   - Required: halt with cause=2, cycle_count=64, retire_count=64, trace_level=4.
// - Backpressure and reset mid-drain:
//   - Hold trace_ready=0 for 3 cycles: trace_data is unchanged.
//   - Pop 1 entry, then assert rst: halted=0, trace_level=0, counters=0.
//   - A new run after reset reaches the breakpoint again.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU debug/trace blocks: halt causes, monitor states
// and a width helper for breakpoint channel indices.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_BP      = 2'd1,
        HC_TIMEOUT = 2'd2
    } halt_cause_t;

    typedef enum logic {
        MON_RUN    = 1'b0,
        MON_HALTED = 1'b1
    } mon_state_t;

    // A single breakpoint channel still needs a 1-bit index port.
    function automatic int bpIdxWidth(input int numBp);
        return (numBp > 1) ? $clog2(numBp) : 1;
    endfunction

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// Retire stream, breakpoint setup, halt status and trace drain port of the
// run monitor; slave is the monitor side, master is the cpu/debug-host side.
interface cpu_trace_monitor_if
    import cpu_dbg_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32
);
    localparam int BP_W  = bpIdxWidth(NUM_BP);
    localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

    logic                   retire_valid;
    logic [XLEN-1:0]        retire_pc;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*XLEN-1:0] bp_addr;
    logic                   halted;
    logic [1:0]             halt_cause;
    logic [BP_W-1:0]        halt_bp_idx;
    logic [CNT_W-1:0]       cycle_count;
    logic [CNT_W-1:0]       retire_count;
    logic                   trace_valid;
    logic [XLEN-1:0]        trace_data;
    logic                   trace_ready;
    logic [LVL_W-1:0]       trace_level;

    modport slave (
        input  retire_valid, retire_pc, bp_en, bp_addr, trace_ready,
        output halted, halt_cause, halt_bp_idx, cycle_count, retire_count,
               trace_valid, trace_data, trace_level
    );

    modport master (
        output retire_valid, retire_pc, bp_en, bp_addr, trace_ready,
        input  halted, halt_cause, halt_bp_idx, cycle_count, retire_count,
               trace_valid, trace_data, trace_level
    );

endinterface

// File: rtl/cpu_trace_monitor_trace_ring.sv
// Circular buffer of WIDTH x DEPTH entries; a push into a full ring drops the
// oldest entry so the ring always holds the most recent DEPTH values.
module trace_ring #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full;
    logic             popEff;
    logic             dropOld;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty_o = (level_q == '0);
        popEff  = pop_i && !empty_o;
        dropOld = push_i && full && !popEff;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popEff || dropOld) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        // Overwrite-on-full keeps the level pinned at DEPTH.
        if (push_i && !popEff && !full) begin
            level_d = level_q + 1'b1;
        end else if (popEff && !push_i) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];
    assign level_o = level_q;

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run monitor beside the cpu: counts cycles/retires, halts on a breakpoint or
// timeout, and records the last TRACE_DEPTH retired PCs for draining after halt.
module cpu_trace_monitor
    import cpu_dbg_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 16,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_trace_monitor_if.slave   mon
);
    localparam int BP_W = bpIdxWidth(NUM_BP);

    mon_state_t        state_q, state_d;
    halt_cause_t       cause_q, cause_d;
    logic [BP_W-1:0]   bpIdx_q, bpIdx_d;
    logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;
    logic [CNT_W-1:0]  retireCount_q, retireCount_d;
    logic              bpHit;
    logic [BP_W-1:0]   bpIdx;
    logic              timeoutHit;
    logic              running;
    logic              push;
    logic              pop;
    logic              ringEmpty;

    // Scanning from the top down leaves the lowest matching channel in bpIdx.
    always_comb begin
        bpHit = 1'b0;
        bpIdx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (mon.bp_en[i] && (mon.retire_pc == mon.bp_addr[i*XLEN +: XLEN])) begin
                bpHit = 1'b1;
                bpIdx = BP_W'(i);
            end
        end
        bpHit = bpHit && mon.retire_valid;
    end

    assign timeoutHit = (TIMEOUT != 0) && (cycleCount_q == CNT_W'(TIMEOUT - 1));
    assign running    = (state_q == MON_RUN);

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        bpIdx_d       = bpIdx_q;
        cycleCount_d  = cycleCount_q;
        retireCount_d = retireCount_q;
        case (state_q)
            MON_RUN: begin
                if (cycleCount_q != '1) begin
                    cycleCount_d = cycleCount_q + 1'b1;
                end
                if (mon.retire_valid && (retireCount_q != '1)) begin
                    retireCount_d = retireCount_q + 1'b1;
                end
                if (bpHit) begin
                    state_d = MON_HALTED;
                    cause_d = HC_BP;
                    bpIdx_d = bpIdx;
                end else if (timeoutHit) begin
                    state_d = MON_HALTED;
                    cause_d = HC_TIMEOUT;
                end
            end
            MON_HALTED: begin
                state_d = MON_HALTED;
            end
            default: begin
                state_d = MON_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MON_RUN;
            cause_q       <= HC_NONE;
            bpIdx_q       <= '0;
            cycleCount_q  <= '0;
            retireCount_q <= '0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            bpIdx_q       <= bpIdx_d;
            cycleCount_q  <= cycleCount_d;
            retireCount_q <= retireCount_d;
        end
    end

    assign push = running && mon.retire_valid;
    assign pop  = !running && !ringEmpty && mon.trace_ready;

    trace_ring #(
        .WIDTH (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pushData_i (mon.retire_pc),
        .pop_i      (pop),
        .data_o     (mon.trace_data),
        .level_o    (mon.trace_level),
        .empty_o    (ringEmpty)
    );

    assign mon.halted       = !running;
    assign mon.halt_cause   = cause_q;
    assign mon.halt_bp_idx  = bpIdx_q;
    assign mon.cycle_count  = cycleCount_q;
    assign mon.retire_count = retireCount_q;
    assign mon.trace_valid  = !running && !ringEmpty;

endmodule
